// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of the 5-stage MIPS32 pipeline. Holds the PC,
// selects the next PC, drives the instruction-memory address and owns the
// IF/ID pipeline register. A small BOOT/RUN/HALTED controller gates fetching,
// and a saturating counter records stall cycles seen while running.
//
// Ports:
//   clk                   pipeline clock, rising edge
//   rst_n                 asynchronous active-low reset
//   pc_stall              hold PC (hazard unit)
//   IF_ID_pipeline_stall  hold IF/ID register (hazard unit)
//   PCSrc_ID              branch taken, resolved in ID
//   Branch_target_ID      taken-branch target from ID
//   halt_req              level request to stop fetching
//   resume                one-cycle pulse that leaves HALTED
//   imem_rdata            instruction word at imem_addr (combinational read)
//   imem_addr             current PC to instruction memory
//   Instruction_ID        IF/ID instruction
//   PC_plus4_ID           IF/ID PC+4
//   valid_ID              IF/ID holds a real instruction (0 = bubble)
//   fetch_state           00 BOOT, 01 RUN, 10 HALTED
//   stall_count           saturating count of stall cycles in RUN
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pc_stall,
   input  logic                   IF_ID_pipeline_stall,
   input  logic                   PCSrc_ID,
   input  logic [31:0]            Branch_target_ID,
   input  logic                   halt_req,
   input  logic                   resume,
   input  logic [31:0]            imem_rdata,
   output logic [31:0]            imem_addr,
   output logic [31:0]            Instruction_ID,
   output logic [31:0]            PC_plus4_ID,
   output logic                   valid_ID,
   output logic [1:0]             fetch_state,
   output logic [STALL_CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } fetch_state_t;

   // sll $0,$0,0: writes no register and never matches a forwarding source
   localparam logic [31:0]            BUBBLE  = 32'h0000_0000;
   localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
   localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   fetch_state_t           state_r,     state_nxt_s;
   logic [31:0]            pc_r,        pc_nxt_s;
   logic [31:0]            instr_r,     instr_nxt_s;
   logic [31:0]            plus4_r,     plus4_nxt_s;
   logic                   valid_r,     valid_nxt_s;
   logic [STALL_CNT_W-1:0] stall_cnt_r, stall_cnt_nxt_s;
   logic [31:0]            pc_plus4_s;
   logic                   stall_s;

   // 32-bit add wraps naturally: 32'hFFFF_FFFC + 4 = 0
   assign pc_plus4_s = pc_r + 32'd4;
   // A mismatched pair from the hazard unit is still treated as a full stall
   assign stall_s    = pc_stall | IF_ID_pipeline_stall;

   // Next-state and next-register selection for the fetch controller
   always_comb begin
      state_nxt_s     = state_r;
      pc_nxt_s        = pc_r;
      instr_nxt_s     = instr_r;
      plus4_nxt_s     = plus4_r;
      valid_nxt_s     = valid_r;
      stall_cnt_nxt_s = stall_cnt_r;
      case (state_r)
         ST_BOOT: begin
            instr_nxt_s = BUBBLE;
            plus4_nxt_s = 32'h0000_0000;
            valid_nxt_s = 1'b0;
            state_nxt_s = ST_RUN;
         end
         ST_RUN: begin
            if (stall_s) begin
               // Branch operands are not yet valid while stalled, so PCSrc_ID
               // and halt_req are both deferred until the stall clears.
               if (stall_cnt_r != CNT_MAX) begin
                  stall_cnt_nxt_s = stall_cnt_r + CNT_ONE;
               end else begin
                  stall_cnt_nxt_s = stall_cnt_r;
               end
            end else if (PCSrc_ID) begin
               // No delay slot: the wrong-path fetch is replaced by a bubble
               pc_nxt_s    = Branch_target_ID;
               instr_nxt_s = BUBBLE;
               plus4_nxt_s = 32'h0000_0000;
               valid_nxt_s = 1'b0;
            end else if (halt_req) begin
               instr_nxt_s = BUBBLE;
               plus4_nxt_s = 32'h0000_0000;
               valid_nxt_s = 1'b0;
               state_nxt_s = ST_HALTED;
            end else begin
               pc_nxt_s    = pc_plus4_s;
               instr_nxt_s = imem_rdata;
               plus4_nxt_s = pc_plus4_s;
               valid_nxt_s = 1'b1;
            end
         end
         ST_HALTED: begin
            instr_nxt_s = BUBBLE;
            plus4_nxt_s = 32'h0000_0000;
            valid_nxt_s = 1'b0;
            // Leaving HALTED does not fetch; fetch restarts on the next edge
            if (resume) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_HALTED;
            end
         end
         default: begin
            // Unreachable encoding: drain IF/ID and restart via BOOT
            instr_nxt_s = BUBBLE;
            plus4_nxt_s = 32'h0000_0000;
            valid_nxt_s = 1'b0;
            state_nxt_s = ST_BOOT;
         end
      endcase
   end

   // State, PC, IF/ID and stall counter registers with async reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_BOOT;
         pc_r        <= RESET_PC;
         instr_r     <= 32'h0000_0000;
         plus4_r     <= 32'h0000_0000;
         valid_r     <= 1'b0;
         stall_cnt_r <= {STALL_CNT_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         pc_r        <= pc_nxt_s;
         instr_r     <= instr_nxt_s;
         plus4_r     <= plus4_nxt_s;
         valid_r     <= valid_nxt_s;
         stall_cnt_r <= stall_cnt_nxt_s;
      end
   end

   assign imem_addr      = pc_r;
   assign Instruction_ID = instr_r;
   assign PC_plus4_ID    = plus4_r;
   assign valid_ID       = valid_r;
   assign fetch_state    = state_r;
   assign stall_count    = stall_cnt_r;

endmodule
